// File: rtl/ref_bank_loader_if.sv
// Row stream into the reference bank loader.
// One 32-pixel row per beat, valid/ready handshake.
interface ref_bank_loader_if #(
  parameter int PIXEL = 8
);
  logic                 s_valid;
  logic [32*PIXEL-1:0]  s_data;
  logic                 s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/ref_bank_loader.sv
// Write-side controller for the 32-bank circular reference window.
// Optional REF_BANK_LOADER_PIXREV_EN reverses pixel order per row.
module ref_bank_loader #(
  parameter int PIXEL = 8,
  parameter int DEPTH = 96
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [9:0]          base_row,
  input  logic [9:0]          num_rows,
  ref_bank_loader_if.slave    s,
  output logic [32*PIXEL-1:0] ref_input,
  output logic [31:0]         Bank_sel,
  output logic [7*32-1:0]     write_address_all,
  output logic                busy,
  output logic                done
);

  localparam logic [9:0] CAP = 10'(8 * DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [9:0]          cur_row;
  logic [9:0]          remaining;
  logic [9:0]          base_eff;
  logic [9:0]          num_eff;
  logic                acc;
  logic [2:0]          grp;
  logic [6:0]          addr;
  logic [32*PIXEL-1:0] row_in;

  assign s.s_ready = (state == S_LOAD);
  assign acc       = s.s_valid && s.s_ready;

  assign base_eff = (base_row >= CAP) ? base_row - CAP : base_row;
  assign num_eff  = (num_rows > CAP) ? CAP : num_rows;

  // Rows interleave across the 8 bank groups, address advances every 8 rows
  assign grp  = cur_row[2:0];
  assign addr = cur_row[9:3];

`ifdef REF_BANK_LOADER_PIXREV_EN
  always_comb begin
    row_in = '0;
    for (int i = 0; i < 32; i++) begin
      row_in[PIXEL*i +: PIXEL] = s.s_data[PIXEL*(31-i) +: PIXEL];
    end
  end
`else
  assign row_in = s.s_data;
`endif

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (start) begin
          state_nx = (num_eff == 10'd0) ? S_FIN : S_LOAD;
        end
      end
      (state == S_LOAD): begin
        if (acc && remaining == 10'd1) begin
          state_nx = S_FIN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      cur_row           <= '0;
      remaining         <= '0;
      ref_input         <= '0;
      Bank_sel          <= '0;
      write_address_all <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != S_IDLE);
      done     <= (state_nx == S_FIN);
      Bank_sel <= '0;
      if (state == S_IDLE && start) begin
        cur_row   <= base_eff;
        remaining <= num_eff;
      end
      if (acc) begin
        Bank_sel  <= 32'hF << {grp, 2'b00};
        ref_input <= row_in;
        for (int j = 0; j < 32; j++) begin
          if ((j / 4) == int'(grp)) begin
            write_address_all[7*j +: 7] <= addr;
          end
        end
        cur_row   <= (cur_row == CAP - 10'd1) ? 10'd0 : cur_row + 10'd1;
        remaining <= remaining - 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_ref_bank_loader.sv
// Bench for ref_bank_loader: row-level model plus directed loads.
// Honours REF_BANK_LOADER_PIXREV_EN when defined.
module tb_ref_bank_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   base_row = '0;
  logic [9:0]   num_rows = '0;
  logic [255:0] ref_input;
  logic [31:0]  Bank_sel;
  logic [223:0] write_address_all;
  logic         busy;
  logic         done;

  ref_bank_loader_if #(.PIXEL(8)) sif ();

  ref_bank_loader #(.PIXEL(8), .DEPTH(96)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_row          (base_row),
    .num_rows          (num_rows),
    .s                 (sif),
    .ref_input         (ref_input),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rev(input logic [255:0] d);
    logic [255:0] r;
    r = d;
`ifdef REF_BANK_LOADER_PIXREV_EN
    for (int i = 0; i < 32; i++) r[8*i +: 8] = d[8*(31-i) +: 8];
`endif
    return r;
  endfunction

  // Row-level model: a load is a counter of rows left and a window position
  bit           m_load;
  bit           m_fin;
  int           m_row;
  int           m_left;
  logic [255:0] e_data;
  logic [31:0]  e_sel;
  logic [6:0]   e_addr [32];
  bit           e_done;
  bit           e_busy;

  initial begin
    m_load = 0; m_fin = 0; m_row = 0; m_left = 0;
    e_data = '0; e_sel = '0; e_done = 0; e_busy = 0;
    for (int j = 0; j < 32; j++) e_addr[j] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    bit nf;
    int g;
    int a;
    if (!rst_n) begin
      m_load = 0; m_fin = 0; m_row = 0; m_left = 0;
      e_data = '0; e_sel = '0; e_done = 0; e_busy = 0;
      for (int j = 0; j < 32; j++) e_addr[j] = '0;
    end else begin
      nf = 0;
      e_sel = '0;
      if (!m_load && !m_fin && start) begin
        m_row  = (int'(base_row) >= 768) ? int'(base_row) - 768 : int'(base_row);
        m_left = (int'(num_rows) > 768) ? 768 : int'(num_rows);
        if (m_left == 0) nf = 1;
        else m_load = 1;
      end else if (m_load && sif.s_valid) begin
        g = m_row % 8;
        a = m_row / 8;
        e_sel = 32'hF << (4 * g);
        for (int k = 0; k < 4; k++) e_addr[4*g+k] = 7'(a);
        e_data = rev(sif.s_data);
        m_row  = (m_row + 1) % 768;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_load = 0;
          nf = 1;
        end
      end
      m_fin  = nf;
      e_done = nf;
      e_busy = m_load || m_fin;
    end
  end

  always @(negedge clk) begin
    logic [223:0] ea;
    if (chk_en) begin
      for (int j = 0; j < 32; j++) ea[7*j +: 7] = e_addr[j];
      chk("s_ready", 256'(sif.s_ready), 256'(m_load));
      chk("Bank_sel", 256'(Bank_sel), 256'(e_sel));
      chk("ref_input", ref_input, e_data);
      chk("wr_addr", 256'(write_address_all), 256'(ea));
      chk("busy", 256'(busy), 256'(e_busy));
      chk("done", 256'(done), 256'(e_done));
    end
  end

  // Write log for literal expectations
  int           wcount = 0;
  int           qg[$];
  int           qa[$];
  logic [255:0] last_data = '0;

  always @(negedge clk) begin
    int idx;
    if (Bank_sel != 32'd0) begin
      idx = 0;
      for (int j = 31; j >= 0; j--) if (Bank_sel[j]) idx = j;
      wcount++;
      qg.push_back(idx / 4);
      qa.push_back(int'(write_address_all[7*idx +: 7]));
      last_data = ref_input;
    end
  end

  int salt = 0;
  bit use_ramp = 0;

  function automatic logic [255:0] mkrow(input int c, input int sl,
                                         input bit ramp);
    logic [255:0] d;
    for (int p = 0; p < 32; p++)
      d[8*p +: 8] = ramp ? 8'(p) : 8'(c * 13 + p * 5 + sl * 71);
    return d;
  endfunction

  task automatic clr();
    @(posedge clk);
    #1;
    wcount = 0;
    qg.delete();
    qa.delete();
  endtask

  // mode 0: valid held; mode 1: valid 1,0,0 repeating
  task automatic run_load(input int b, input int n, input int mode,
                          input bit dbl, output int done_at);
    int cyc;
    clr();
    salt++;
    cyc = 0;
    done_at = -1;
    @(negedge clk);
    while (1) begin
      start = (cyc == 0) || (dbl && cyc == 4);
      base_row = (cyc == 0) ? 10'(b) : 10'd3;
      num_rows = (cyc == 0) ? 10'(n) : 10'd2;
      sif.s_valid = (cyc > 0) && (mode == 0 || (cyc - 1) % 3 == 0);
      sif.s_data = mkrow(cyc, salt, use_ramp);
      @(posedge clk);
      #1;
      if (done) begin
        done_at = cyc;
        break;
      end
      if (cyc >= 2000) begin
        errors++;
        checks++;
        $display("FAIL done_timeout: got no done expected done within 2000");
        break;
      end
      cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    start = 0;
    sif.s_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    int da;
    logic [255:0] er;
    int wg[5];
    int wa[5];
    wg = '{5, 6, 7, 0, 1};
    wa = '{95, 95, 95, 0, 0};
    sif.s_valid = 0;
    sif.s_data = '0;
    #2 rst_n = 0;
    #20;
    chk("rst_sel", 256'(Bank_sel), 256'd0);
    chk("rst_data", ref_input, 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_ready", 256'(sif.s_ready), 256'd0);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    run_load(0, 16, 0, 0, da);
    chk("basic_cnt", 256'(wcount), 256'd16);
    chk("basic_done_at", 256'(da), 256'd16);
    chk("basic_last_g", 256'(qg[15]), 256'd7);
    chk("basic_last_a", 256'(qa[15]), 256'd1);

    run_load(100, 8, 1, 0, da);
    chk("gap_cnt", 256'(wcount), 256'd8);
    chk("gap_done_at", 256'(da), 256'd22);

    run_load(765, 5, 0, 0, da);
    chk("wrap_cnt", 256'(wcount), 256'd5);
    for (int i = 0; i < 5 && i < qg.size(); i++) begin
      chk($sformatf("wrap_g%0d", i), 256'(qg[i]), 256'(wg[i]));
      chk($sformatf("wrap_a%0d", i), 256'(qa[i]), 256'(wa[i]));
    end

    run_load(0, 0, 0, 0, da);
    chk("zero_cnt", 256'(wcount), 256'd0);
    chk("zero_done_at", 256'(da), 256'd0);

    run_load(0, 1000, 0, 0, da);
    chk("clamp_cnt", 256'(wcount), 256'd768);

    run_load(800, 2, 0, 0, da);
    chk("base800_g", 256'(qg[0]), 256'd0);
    chk("base800_a", 256'(qa[0]), 256'd4);

    run_load(200, 6, 0, 1, da);
    chk("dbl_cnt", 256'(wcount), 256'd6);

    clr();
    @(negedge clk);
    base_row = 10'd50;
    num_rows = 10'd10;
    start = 1;
    @(negedge clk);
    start = 0;
    sif.s_valid = 1;
    sif.s_data = mkrow(1, 99, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_sel", 256'(Bank_sel), 256'd0);
    chk("mid_rst_data", ref_input, 256'd0);
    chk("mid_rst_addr", 256'(write_address_all), 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    chk("mid_rst_done", 256'(done), 256'd0);
    chk("mid_rst_ready", 256'(sif.s_ready), 256'd0);
    sif.s_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    run_load(10, 2, 0, 0, da);
    chk("fresh_g", 256'(qg[0]), 256'd2);
    chk("fresh_a", 256'(qa[0]), 256'd1);

    use_ramp = 1;
    run_load(0, 1, 0, 0, da);
    for (int i = 0; i < 32; i++) begin
`ifdef REF_BANK_LOADER_PIXREV_EN
      er[8*i +: 8] = 8'(31 - i);
`else
      er[8*i +: 8] = 8'(i);
`endif
    end
    chk("pix_order", last_data, er);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
